instruction_encoder: RTL
========================

# instruction_encoder

Inverse of the instruction decoder: accepts one decoded operation per handshake (opcode number plus operand fields) and assembles the 16-bit XM-23 instruction word. Each word is tagged with a sequential word address and buffered in a small FIFO for a program loader or memory writer downstream. Used by the self-test/boot loader to build instruction streams in hardware, and as a round-trip check against the decoder.

## Interface
- BASE_ADDR, 16'h0000, address tag of the first word after reset; must be even
- DEPTH, 2, output FIFO entries (power of two, 2..8)
- Clock  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- In_valid  in  1  operation presented
- In_ready  out  1  encoder can accept; equals !full
- OP  in  7  operation number, same numbering the decoder emits (0 BL … 41 BREAKPOINT)
- OFF  in  13  branch/relative offset; only the low bits each format uses are taken
- C, T, F  in  4, 3, 3  CEX condition, true count, false count
- PR  in  3  SETPRI priority
- SA  in  4  SVC number
- PSWb  in  5  SETCC/CLRCC bits
- DST, SRCCON  in  3, 3  destination register, source register/constant
- WB, RC, PRPO, DEC, INC  in  1 each  word/byte, reg/const, pre/post, decrement, increment
- ImByte  in  8  MOVx immediate byte
- Out_valid  out  1  FIFO head valid
- Out_ready  in  1  downstream takes head
- Instr_out  out  16  encoded word at FIFO head
- Addr_out  out  16  address tag of head word
- FLTo  out  1  one-cycle pulse: rejected opcode
- Fault_count  out  8  saturating count of rejected opcodes

## Operation
- Accept when In_valid && In_ready at a rising edge; fields sampled that edge.
- Encodings (bit 15 left):
  - OP0 BL: 000, OFF[12:0].
  - OP1–8 BEQ..BRA: 001, [12:10]=OP-1, OFF[9:0].
  - OP9–20 ADD..BIS: 010, [12]=0, [11:8]=OP-9, RC[7], WB[6], SRCCON[5:3], DST[2:0].
  - OP21/22 MOV/SWAP: 010 011, [9:8]=00, [7]=OP-21, WB, SRCCON, DST.
  - OP23–26 SRA/RRC/SWPB/SXT: 010 011 010, WB[6], [5:3]=OP-23, DST.
  - OP28–31 SETPRI/SVC/SETCC/CLRCC: 010 011 011, [6:5]=OP-28; SETPRI [4:3]=00, [2:0]=PR; SVC [4]=0, [3:0]=SA; SETCC/CLRCC [4:0]=PSWb.
  - OP32 CEX: 010 100, C[9:6], T[5:3], F[2:0].
  - OP33/34 LD/ST: 010, [12:10]=110/111, PRPO[9], DEC[8], INC[7], WB, SRCCON, DST.
  - OP35–38 MOVL/MOVLZ/MOVLS/MOVH: 011, [12:11]=OP-35, ImByte[10:3], DST.
  - OP39/40 LDR/STR: [15:14]=10/11, OFF[6:0] at [13:7], WB, SRCCON, DST.
  - OP41 BREAKPOINT: 16'h5400.
- OP27 or OP>41: no push, address unchanged, FLTo=1 next cycle, Fault_count+1 (holds at 255).
- Valid accept pushes {word, addr}; addr counter += 2, wraps 16'hFFFE→16'h0000.
- Pop when Out_valid && Out_ready. Push and pop same edge: occupancy unchanged, order kept.
- Full: In_ready=0; input ignored even if a pop happens same edge (no bypass).

## Timing
- Reset (Reset_n low at edge): FIFO empty, Out_valid=0, Instr_out=0, Addr_out=0, FLTo=0, Fault_count=0, addr counter=BASE_ADDR, In_ready=1 from next cycle.
- Reset overrides any simultaneous accept/pop; in-flight entries discarded.
- Latency: accepted at edge N → Out_valid/Instr_out/Addr_out visible after edge N (registered, one cycle) when FIFO was empty.
- In_ready and Out_valid derive only from registered occupancy (no combinational path from In_valid/Out_ready).
- Instr_out/Addr_out hold last head value when empty.
- Throughput: one word/cycle with Out_ready held high.

## Test plan
- Reset, then ADD (OP9, RC=0, WB=1, SRCCON=3, DST=5) with Out_ready=1 → Instr_out=16'h405D, Addr_out=BASE_ADDR next cycle.
- Stream BL OFF=13'h1ABC, BNE(OP2) OFF=10'h3FF, MOVH ImByte=8'hA5 DST=2, STR OFF=7'h7F WB=0 SRCCON=1 DST=0, BREAKPOINT → 16'h1ABC, 16'h27FF, 16'h7D2A, 16'hFF88, 16'h5400 at addrs 0,2,4,6,8.
- OP27 then OP50 between valid ops → two FLTo pulses, Fault_count=2, no words pushed, next valid word keeps contiguous address.
- Out_ready=0, push DEPTH words → In_ready=0, further In_valid ignored; release Out_ready → words drain in order, In_ready=1.
- BASE_ADDR=16'hFFFC, push 3 words → tags FFFC, FFFE, 0000.
- Reset_n low mid-stream with 2 words buffered → Out_valid=0, Fault_count=0, next word tagged BASE_ADDR.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - operation-in / instruction-word-out bundle for instruction_encoder
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [12:0] off;
    logic [3:0]  c;
    logic [2:0]  t;
    logic [2:0]  f;
    logic [2:0]  pr;
    logic [3:0]  sa;
    logic [4:0]  pswb;
    logic [2:0]  dst;
    logic [2:0]  srccon;
    logic        wb;
    logic        rc;
    logic        prpo;
    logic        dec;
    logic        inc;
    logic [7:0]  imbyte;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr_out;
    logic [15:0] addr_out;

    modport master (
        output in_valid, op, off, c, t, f, pr, sa, pswb, dst, srccon,
               wb, rc, prpo, dec, inc, imbyte, out_ready,
        input  in_ready, out_valid, instr_out, addr_out
    );

    modport slave (
        input  in_valid, op, off, c, t, f, pr, sa, pswb, dst, srccon,
               wb, rc, prpo, dec, inc, imbyte, out_ready,
        output in_ready, out_valid, instr_out, addr_out
    );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - XM-23 operation-to-instruction-word encoder with tagged output FIFO
module instruction_encoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          DEPTH     = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    instruction_encoder_if.slave  bus,
    output logic                  flto,
    output logic [7:0]            fault_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   word;
    logic          op_bad;
    logic [15:0]   mem_w [DEPTH];
    logic [15:0]   mem_a [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [15:0]   addr_cnt;
    logic [15:0]   head_w_nxt;
    logic [15:0]   head_a_nxt;
    logic          accept;
    logic          push;
    logic          pop;

    // Handshakes depend only on registered occupancy.
    assign bus.in_ready  = (count != CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && !op_bad;
    assign pop           = bus.out_valid && bus.out_ready;

    // Assemble the instruction word; OP-k subtractions use only the low bits they affect.
    always_comb begin
        word   = '0;
        op_bad = 1'b0;
        case (bus.op) inside
            7'd0:           word = {3'b000, bus.off};
            [7'd1:7'd8]:    word = {3'b001, bus.op[2:0] - 3'd1, bus.off[9:0]};
            [7'd9:7'd20]:   word = {3'b010, 1'b0, bus.op[3:0] - 4'd9, bus.rc, bus.wb,
                                    bus.srccon, bus.dst};
            7'd21, 7'd22:   word = {6'b010011, 2'b00, ~bus.op[0], bus.wb, bus.srccon, bus.dst};
            [7'd23:7'd26]:  word = {9'b010011010, bus.wb, bus.op[2:0] + 3'd1, bus.dst};
            7'd28:          word = {9'b010011011, 2'b00, 2'b00, bus.pr};
            7'd29:          word = {9'b010011011, 2'b01, 1'b0, bus.sa};
            7'd30:          word = {9'b010011011, 2'b10, bus.pswb};
            7'd31:          word = {9'b010011011, 2'b11, bus.pswb};
            7'd32:          word = {6'b010100, bus.c, bus.t, bus.f};
            7'd33, 7'd34:   word = {3'b010, 2'b11, ~bus.op[0], bus.prpo, bus.dec, bus.inc,
                                    bus.wb, bus.srccon, bus.dst};
            [7'd35:7'd38]:  word = {3'b011, bus.op[1:0] + 2'd1, bus.imbyte, bus.dst};
            7'd39, 7'd40:   word = {1'b1, ~bus.op[0], bus.off[6:0], bus.wb, bus.srccon, bus.dst};
            7'd41:          word = 16'h5400;
            default:        op_bad = 1'b1;
        endcase
    end

    // Next occupancy, next read pointer and the value the head registers should show.
    always_comb begin
        count_nxt  = count;
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
        head_w_nxt = bus.instr_out;
        head_a_nxt = bus.addr_out;
        if (count_nxt != '0) begin
            if (push && (wr_ptr == rd_ptr_nxt)) begin
                head_w_nxt = word;
                head_a_nxt = addr_cnt;
            end else begin
                head_w_nxt = mem_w[rd_ptr_nxt];
                head_a_nxt = mem_a[rd_ptr_nxt];
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_w[wr_ptr] <= word;
            mem_a[wr_ptr] <= addr_cnt;
        end
    end

    // Pointers, occupancy, address tag counter and registered head outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            addr_cnt      <= BASE_ADDR;
            bus.instr_out <= '0;
            bus.addr_out  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_cnt <= addr_cnt + 16'd2;
            end
            rd_ptr        <= rd_ptr_nxt;
            count         <= count_nxt;
            bus.instr_out <= head_w_nxt;
            bus.addr_out  <= head_a_nxt;
        end
    end

    // Rejected-opcode pulse and saturating fault counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            flto        <= 1'b0;
            fault_count <= '0;
        end else begin
            flto <= accept && op_bad;
            if (accept && op_bad && (fault_count != 8'hFF)) begin
                fault_count <= fault_count + 8'd1;
            end
        end
    end

endmodule
